bayer_line_reader: RTL

BAYER_LINE_READER -- requirements
Module: bayer_line_reader

---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/bayer_line_reader_if.sv | 26 ++
 rtl/bayer_2x2.sv | 65 ++++++
 rtl/bayer_line_reader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, FSM state types, Bayer parity encoding and
// the green-average helper used by the line reader and its demosaic stage.
package vga_timing_pkg;

  localparam int H_SYNC_D  = 96;
  localparam int H_BACK_D  = 48;
  localparam int H_ACT_D   = 640;
  localparam int H_FRONT_D = 16;
  localparam int V_SYNC_D  = 2;
  localparam int V_BACK_D  = 33;
  localparam int V_ACT_D   = 480;
  localparam int V_FRONT_D = 10;

  typedef enum logic [1:0] {H_SYNC_S, H_BACK_S, H_ACT_S, H_FRONT_S} h_state_t;
  typedef enum logic [1:0] {V_SYNC_S, V_BACK_S, V_ACT_S, V_FRONT_S} v_state_t;

  // Bayer site parity, encoded as {y[0], x[0]}
  typedef enum logic [1:0] {PAR_00 = 2'b00, PAR_01 = 2'b01,
                            PAR_10 = 2'b10, PAR_11 = 2'b11} parity_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  function automatic logic [7:0] avg8(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    logic [11:0] h;
    s = {1'b0, a} + {1'b0, b};
    h = s[12:1];
    return h[11:4];
  endfunction

endpackage

// File: rtl/bayer_line_reader_if.sv
// Line-buffer read port plus demosaiced VGA output bundle of bayer_line_reader.
interface bayer_line_reader_if;
  logic [11:0] taps0x;
  logic [11:0] taps1x;
  logic        READ_Request;
  logic [12:0] READ_Cont;
  logic [12:0] V_Cont;
  logic [7:0]  oVGA_R;
  logic [7:0]  oVGA_G;
  logic [7:0]  oVGA_B;
  logic        oVGA_HS;
  logic        oVGA_VS;
  logic        oVGA_DE;

  modport slave (
    input  taps0x, taps1x,
    output READ_Request, READ_Cont, V_Cont,
    output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_DE
  );

  modport master (
    output taps0x, taps1x,
    input  READ_Request, READ_Cont, V_Cont,
    input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_DE
  );
endinterface

// File: rtl/bayer_2x2.sv
// 2x2 Bayer demosaic: current/previous column taps of two lines in, one
// registered RGB pixel out; output is zero whenever the input is not valid.
module bayer_2x2
  import vga_timing_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  parity_t     i_par,
  input  logic [11:0] i_cur0,
  input  logic [11:0] i_cur1,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b
);
  logic [11:0] r_prev0, r_prev1;
  logic [7:0]  r_r, r_g, r_b;
  logic [7:0]  w_r, w_g, w_b;

  always_comb begin
    w_r = i_cur0[11:4];
    w_g = avg8(r_prev0, i_cur1);
    w_b = r_prev1[11:4];
    case (i_par)
      PAR_01: begin
        w_r = r_prev0[11:4];
        w_g = avg8(i_cur0, r_prev1);
        w_b = i_cur1[11:4];
      end
      PAR_10: begin
        w_r = i_cur1[11:4];
        w_g = avg8(r_prev1, i_cur0);
        w_b = r_prev0[11:4];
      end
      PAR_11: begin
        w_r = r_prev1[11:4];
        w_g = avg8(i_cur1, r_prev0);
        w_b = i_cur0[11:4];
      end
      default: ;
    endcase
  end

  // prev taps fall to zero between lines so column 0 sees an empty neighbour
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev0 <= '0;
      r_prev1 <= '0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
    end else begin
      r_prev0 <= i_vld ? i_cur0 : 12'd0;
      r_prev1 <= i_vld ? i_cur1 : 12'd0;
      r_r     <= i_vld ? w_r : 8'd0;
      r_g     <= i_vld ? w_g : 8'd0;
      r_b     <= i_vld ? w_b : 8'd0;
    end
  end

  assign o_r = r_r;
  assign o_g = r_g;
  assign o_b = r_b;

endmodule

// File: rtl/bayer_line_reader.sv
// VGA timing generator that reads a two-line Bayer buffer and emits RGB.
// Optional BAYER_MIRROR_EN: horizontally mirrored read with swapped column parity.
module bayer_line_reader
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_D,
  parameter int H_BACK  = H_BACK_D,
  parameter int H_ACT   = H_ACT_D,
  parameter int H_FRONT = H_FRONT_D,
  parameter int V_SYNC  = V_SYNC_D,
  parameter int V_BACK  = V_BACK_D,
  parameter int V_ACT   = V_ACT_D,
  parameter int V_FRONT = V_FRONT_D
)(
  input  logic                VGA_CLK,
  input  logic                RESET,
  bayer_line_reader_if.slave  bus
);
`ifdef BAYER_MIRROR_EN
  localparam logic MIRROR = 1'b1;
`else
  localparam logic MIRROR = 1'b0;
`endif

  h_state_t    r_h_state, w_h_state_nxt;
  logic [11:0] r_h_cnt, w_h_cnt_nxt, w_h_last;
  v_state_t    r_v_state, w_v_state_nxt;
  logic [12:0] r_v_cnt, w_v_cnt_nxt, w_v_last;
  logic        w_h_end, w_line_end, w_act_nxt;

  logic        r_req, r_x0;
  logic [12:0] r_cont, r_vcont;
  parity_t     r_par_d1;
  sync_t [2:1] r_sync_pipe;
  sync_t       w_sync;

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_h_state <= H_SYNC_S;
      r_h_cnt   <= '0;
      r_v_state <= V_SYNC_S;
      r_v_cnt   <= '0;
    end else begin
      r_h_state <= w_h_state_nxt;
      r_h_cnt   <= w_h_cnt_nxt;
      r_v_state <= w_v_state_nxt;
      r_v_cnt   <= w_v_cnt_nxt;
    end
  end

  always_comb begin
    w_h_last = 12'(H_SYNC - 1);
    case (r_h_state)
      H_BACK_S:  w_h_last = 12'(H_BACK - 1);
      H_ACT_S:   w_h_last = 12'(H_ACT - 1);
      H_FRONT_S: w_h_last = 12'(H_FRONT - 1);
      default: ;
    endcase
    w_h_end       = (r_h_cnt == w_h_last);
    w_line_end    = w_h_end && (r_h_state == H_FRONT_S);
    w_h_state_nxt = r_h_state;
    w_h_cnt_nxt   = r_h_cnt + 12'd1;
    if (w_h_end) begin
      w_h_cnt_nxt = '0;
      case (r_h_state)
        H_SYNC_S: w_h_state_nxt = H_BACK_S;
        H_BACK_S: w_h_state_nxt = H_ACT_S;
        H_ACT_S:  w_h_state_nxt = H_FRONT_S;
        default:  w_h_state_nxt = H_SYNC_S;
      endcase
    end
  end

  // vertical machine steps only on the line boundary (HFRONT -> HSYNC)
  always_comb begin
    w_v_last = 13'(V_SYNC - 1);
    case (r_v_state)
      V_BACK_S:  w_v_last = 13'(V_BACK - 1);
      V_ACT_S:   w_v_last = 13'(V_ACT - 1);
      V_FRONT_S: w_v_last = 13'(V_FRONT - 1);
      default: ;
    endcase
    w_v_state_nxt = r_v_state;
    w_v_cnt_nxt   = r_v_cnt;
    if (w_line_end) begin
      w_v_cnt_nxt = r_v_cnt + 13'd1;
      if (r_v_cnt == w_v_last) begin
        w_v_cnt_nxt = '0;
        case (r_v_state)
          V_SYNC_S: w_v_state_nxt = V_BACK_S;
          V_BACK_S: w_v_state_nxt = V_ACT_S;
          V_ACT_S:  w_v_state_nxt = V_FRONT_S;
          default:  w_v_state_nxt = V_SYNC_S;
        endcase
      end
    end
  end

  assign w_act_nxt = (w_h_state_nxt == H_ACT_S) && (w_v_state_nxt == V_ACT_S);

  always_comb begin
    w_sync.hs = (r_h_state != H_SYNC_S);
    w_sync.vs = (r_v_state != V_SYNC_S);
    w_sync.de = r_req;
  end

  // Read port is registered from next-state so it lines up with the FSM cycle
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      r_req       <= 1'b0;
      r_cont      <= '0;
      r_vcont     <= '0;
      r_x0        <= 1'b0;
      r_par_d1    <= PAR_00;
      r_sync_pipe <= {SYNC_RST, SYNC_RST};
    end else begin
      r_req   <= w_act_nxt;
      r_cont  <= !w_act_nxt ? 13'd0 :
                 MIRROR     ? 13'(H_ACT - 1) - {1'b0, w_h_cnt_nxt} : {1'b0, w_h_cnt_nxt};
      r_vcont <= (w_v_state_nxt == V_ACT_S) ? w_v_cnt_nxt : 13'd0;
      r_x0    <= w_h_cnt_nxt[0];
      r_par_d1       <= parity_t'({r_vcont[0], r_x0 ^ MIRROR});
      r_sync_pipe[1] <= w_sync;
      r_sync_pipe[2] <= r_sync_pipe[1];
    end
  end

  // taps arrive one cycle after the address; stage 1 of the sync pipe is that cycle
  bayer_2x2 u_demosaic (
    .i_clk  (VGA_CLK),
    .i_rst  (RESET),
    .i_vld  (r_sync_pipe[1].de),
    .i_par  (r_par_d1),
    .i_cur0 (bus.taps0x),
    .i_cur1 (bus.taps1x),
    .o_r    (bus.oVGA_R),
    .o_g    (bus.oVGA_G),
    .o_b    (bus.oVGA_B)
  );

  assign bus.READ_Request = r_req;
  assign bus.READ_Cont    = r_cont;
  assign bus.V_Cont       = r_vcont;
  assign bus.oVGA_HS      = r_sync_pipe[2].hs;
  assign bus.oVGA_VS      = r_sync_pipe[2].vs;
  assign bus.oVGA_DE      = r_sync_pipe[2].de;

endmodule
